// File: rtl/display_pkg.sv
// Shared 640x480 raster timing, colour constants and sync/blank strobe type
// used by the scan generator and the paddle, ball and field renderers.
package display_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = 800;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = 525;

  localparam logic [23:0] COLOR_BLACK  = 24'h000000;
  localparam logic [23:0] COLOR_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] COLOR_FIELD  = 24'h0A6E2A;
  localparam logic [23:0] COLOR_BALL   = 24'hFFD700;
  localparam logic [23:0] COLOR_PADDLE = 24'hE0E0E0;

  // Counters are sized for totals up to 1024; the divider for CLK_DIV up to 16.
  localparam int CNT_W = 10;
  localparam int DIV_W = 4;
  localparam int POS_W = 16;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } strobe_t;

  // Strobe values at scan position (0,0).
  localparam strobe_t STROBE_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0};

  function automatic logic in_span(input logic [CNT_W-1:0] val, input int lo, input int len);
    return (val >= CNT_W'(lo)) && (val < CNT_W'(lo + len));
  endfunction

endpackage

// File: rtl/pos_dbuf.sv
// One paddle coordinate: a shadow register written by game logic and an
// active copy that the renderers see, refreshed once per frame.
module pos_dbuf
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [POS_W-1:0] wdata,
  input  logic             copy_en,
  output logic [POS_W-1:0] active
);

  logic [POS_W-1:0] shadow_q, shadow_d;
  logic [POS_W-1:0] active_q, active_d;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en)   shadow_d = wdata;
    if (copy_en) active_d = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      // NOTE: non-blocking updates mean a write on the copy clock is seen only at the next copy.
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/scan_timing_gen.sv
// Raster scan generator: pixel divider, h/v counters, delayed sync/blank
// strobes, frame pulse and the frame-stable paddle position buffers.
module scan_timing_gen
  import display_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int PIPE_DLY = 1,
  parameter int H_VIS    = H_VISIBLE,
  parameter int H_FRONT  = H_FP,
  parameter int H_SYNC_W = H_SYNC,
  parameter int H_BACK   = H_BP,
  parameter int V_VIS    = V_VISIBLE,
  parameter int V_FRONT  = V_FP,
  parameter int V_SYNC_W = V_SYNC,
  parameter int V_BACK   = V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p1_x_wr,
  input  logic             p1_y_wr,
  input  logic             p2_x_wr,
  input  logic             p2_y_wr,
  input  logic [POS_W-1:0] pos_wdata,
  output logic             pix_tick,
  output logic [POS_W-1:0] pixel_x,
  output logic [POS_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             frame_start,
  output logic [POS_W-1:0] p1_x_loc,
  output logic [POS_W-1:0] p1_y_loc,
  output logic [POS_W-1:0] p2_x_loc,
  output logic [POS_W-1:0] p2_y_loc
);

  localparam int H_TOT = H_VIS + H_FRONT + H_SYNC_W + H_BACK;
  localparam int V_TOT = V_VIS + V_FRONT + V_SYNC_W + V_BACK;
  localparam int SB    = $bits(strobe_t);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] V_COPY   = CNT_W'(V_VIS);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             frame_q, frame_d;
  logic             copy_en;
  strobe_t          raw;
  strobe_t          strobe;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    // Registered compare so the tick stays low in reset even when CLK_DIV=1.
    tick_d = (div_d == DIV_LAST);

    h_d = h_q;
    v_d = v_q;
    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    frame_d = tick_q && (h_q == H_LAST) && (v_q == V_LAST);
    copy_en = tick_q && (h_q == '0) && (v_q == V_COPY);

    raw.hsync = ~in_span(h_q, H_VIS + H_FRONT, H_SYNC_W);
    raw.vsync = ~in_span(v_q, V_VIS + V_FRONT, V_SYNC_W);
    raw.blank = (h_q >= CNT_W'(H_VIS)) || (v_q >= CNT_W'(V_VIS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_direct
      assign strobe = raw;
    end else begin : g_delay
      // Newest stage in the low bits; the output is the oldest stage.
      logic [PIPE_DLY*SB-1:0] line_q, line_d;

      always_comb begin
        line_d = line_q;
        if (tick_q) line_d = (line_q << SB) | (PIPE_DLY*SB)'(raw);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) line_q <= {PIPE_DLY{STROBE_IDLE}};
        else        line_q <= line_d;
      end

      assign strobe = line_q[PIPE_DLY*SB-1 -: SB];
    end
  endgenerate

  pos_dbuf u_p1_x (.clk(clk), .rst_n(rst_n), .wr_en(p1_x_wr), .wdata(pos_wdata),
                   .copy_en(copy_en), .active(p1_x_loc));
  pos_dbuf u_p1_y (.clk(clk), .rst_n(rst_n), .wr_en(p1_y_wr), .wdata(pos_wdata),
                   .copy_en(copy_en), .active(p1_y_loc));
  pos_dbuf u_p2_x (.clk(clk), .rst_n(rst_n), .wr_en(p2_x_wr), .wdata(pos_wdata),
                   .copy_en(copy_en), .active(p2_x_loc));
  pos_dbuf u_p2_y (.clk(clk), .rst_n(rst_n), .wr_en(p2_y_wr), .wdata(pos_wdata),
                   .copy_en(copy_en), .active(p2_y_loc));

  assign pix_tick    = tick_q;
  assign pixel_x     = POS_W'(h_q);
  assign pixel_y     = POS_W'(v_q);
  assign hsync       = strobe.hsync;
  assign vsync       = strobe.vsync;
  assign blank       = strobe.blank;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_scan_timing_gen.sv
// Bench for scan_timing_gen: full 640x480 timing plus two shrunk rasters,
// all compared every clock against an arithmetic model of the scan.
module tb_scan_timing_gen;

  typedef struct {
    int cd;  int dly;
    int hv;  int hfp; int hs; int hbp;
    int vv;  int vfp; int vs; int vbp;
  } cfg_t;

  localparam int NCFG = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr;
  logic [15:0] wdata;

  logic        tk [NCFG];
  logic [15:0] px [NCFG];
  logic [15:0] py [NCFG];
  logic        hs [NCFG];
  logic        vs [NCFG];
  logic        bl [NCFG];
  logic        fs [NCFG];
  logic [15:0] loc [NCFG][4];

  cfg_t        cfg [NCFG];
  logic [15:0] shadow_m [4];
  logic [15:0] act_m [NCFG][4];

  int n;            // clock edges since the latest reset release
  int cyc;          // total stepped clocks
  bit first_pass;
  int n_checks;
  int n_fail;
  int hs_low_cnt;
  int b_fall_x;

  always #5 clk = ~clk;

  scan_timing_gen #(.CLK_DIV(4), .PIPE_DLY(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .p1_x_wr(wr[0]), .p1_y_wr(wr[1]), .p2_x_wr(wr[2]), .p2_y_wr(wr[3]), .pos_wdata(wdata),
    .pix_tick(tk[0]), .pixel_x(px[0]), .pixel_y(py[0]), .hsync(hs[0]), .vsync(vs[0]),
    .blank(bl[0]), .frame_start(fs[0]),
    .p1_x_loc(loc[0][0]), .p1_y_loc(loc[0][1]), .p2_x_loc(loc[0][2]), .p2_y_loc(loc[0][3]));

  scan_timing_gen #(.CLK_DIV(2), .PIPE_DLY(2),
    .H_VIS(16), .H_FRONT(2), .H_SYNC_W(4), .H_BACK(3),
    .V_VIS(12), .V_FRONT(2), .V_SYNC_W(2), .V_BACK(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .p1_x_wr(wr[0]), .p1_y_wr(wr[1]), .p2_x_wr(wr[2]), .p2_y_wr(wr[3]), .pos_wdata(wdata),
    .pix_tick(tk[1]), .pixel_x(px[1]), .pixel_y(py[1]), .hsync(hs[1]), .vsync(vs[1]),
    .blank(bl[1]), .frame_start(fs[1]),
    .p1_x_loc(loc[1][0]), .p1_y_loc(loc[1][1]), .p2_x_loc(loc[1][2]), .p2_y_loc(loc[1][3]));

  scan_timing_gen #(.CLK_DIV(1), .PIPE_DLY(0),
    .H_VIS(16), .H_FRONT(2), .H_SYNC_W(4), .H_BACK(3),
    .V_VIS(12), .V_FRONT(2), .V_SYNC_W(2), .V_BACK(3)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .p1_x_wr(wr[0]), .p1_y_wr(wr[1]), .p2_x_wr(wr[2]), .p2_y_wr(wr[3]), .pos_wdata(wdata),
    .pix_tick(tk[2]), .pixel_x(px[2]), .pixel_y(py[2]), .hsync(hs[2]), .vsync(vs[2]),
    .blank(bl[2]), .frame_start(fs[2]),
    .p1_x_loc(loc[2][0]), .p1_y_loc(loc[2][1]), .p2_x_loc(loc[2][2]), .p2_y_loc(loc[2][3]));

  function automatic int htot(input cfg_t c);
    return c.hv + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int vtot(input cfg_t c);
    return c.vv + c.vfp + c.vs + c.vbp;
  endfunction

  // Pixel ticks completed after k clock edges since release.
  function automatic int ticks_done(input cfg_t c, input int k);
    if (k <= 0) return 0;
    if (c.cd == 1) return k - 1;
    return k / c.cd;
  endfunction

  function automatic bit tick_at(input cfg_t c, input int k);
    return (k >= 1) && (k % c.cd == c.cd - 1);
  endfunction

  function automatic bit copy_at(input cfg_t c, input int k);
    int p;
    p = ticks_done(c, k);
    return tick_at(c, k) && (p % htot(c) == 0) && ((p / htot(c)) % vtot(c) == c.vv);
  endfunction

  function automatic string tag(input string s, input int i);
    return $sformatf("%s[%0d] n=%0d", s, i, n);
  endfunction

  task automatic check(input string t, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", t, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCFG; i++) begin
      int p, pd, hx, vy, hd, vd;
      bit fs_e, hs_e, vs_e, bl_e;
      p    = ticks_done(cfg[i], n);
      pd   = (p >= cfg[i].dly) ? p - cfg[i].dly : 0;
      hx   = p % htot(cfg[i]);
      vy   = (p / htot(cfg[i])) % vtot(cfg[i]);
      hd   = pd % htot(cfg[i]);
      vd   = (pd / htot(cfg[i])) % vtot(cfg[i]);
      fs_e = (n >= 1) && (p != ticks_done(cfg[i], n - 1)) &&
             (p % (htot(cfg[i]) * vtot(cfg[i])) == 0);
      hs_e = !((hd >= cfg[i].hv + cfg[i].hfp) && (hd < cfg[i].hv + cfg[i].hfp + cfg[i].hs));
      vs_e = !((vd >= cfg[i].vv + cfg[i].vfp) && (vd < cfg[i].vv + cfg[i].vfp + cfg[i].vs));
      bl_e = (hd >= cfg[i].hv) || (vd >= cfg[i].vv);
      check(tag("pix_tick", i),    16'(tk[i]), 16'(tick_at(cfg[i], n)));
      check(tag("pixel_x", i),     px[i],      16'(hx));
      check(tag("pixel_y", i),     py[i],      16'(vy));
      check(tag("hsync", i),       16'(hs[i]), 16'(hs_e));
      check(tag("vsync", i),       16'(vs[i]), 16'(vs_e));
      check(tag("blank", i),       16'(bl[i]), 16'(bl_e));
      check(tag("frame_start", i), 16'(fs[i]), 16'(fs_e));
      for (int k = 0; k < 4; k++)
        check(tag($sformatf("loc%0d", k), i), loc[i][k], act_m[i][k]);
    end
  endtask

  // Test-plan spot checks against fixed numbers, first run after power-up only.
  task automatic directed();
    if (first_pass) begin
      if (n == 3 || n == 7)   check("a_tick_period", 16'(tk[0]), 16'd1);
      if (n == 3199) begin
        check("a_x_799", px[0], 16'd799);
        check("a_y_0",   py[0], 16'd0);
      end
      if (n == 3203) begin
        check("a_wrap_x", px[0], 16'd0);
        check("a_wrap_y", py[0], 16'd1);
      end
      if (tk[0] && py[0] == 16'd0 && !hs[0]) hs_low_cnt++;
      if (n == 3210) check("a_hsync_ticks", 16'(hs_low_cnt), 16'd96);
      if (tk[0] && py[0] == 16'd0 && px[0] == 16'd640) check("a_blank_640", 16'(bl[0]), 16'd1);
      if (tk[0] && py[0] == 16'd0 && px[0] == 16'd639) check("a_blank_639", 16'(bl[0]), 16'd0);
      if (b_fall_x < 0 && !hs[1]) b_fall_x = int'(px[1]);
      if (n == 100)  check("b_hsync_fall_x", 16'(b_fall_x), 16'd20);
      if (n == 600)  check("b_p1x_before_copy", loc[1][0], 16'h0000);
      if (n == 602)  check("b_p1x_after_copy",  loc[1][0], 16'h0123);
      if (n == 1550) check("b_p1x_held",        loc[1][0], 16'h0123);
      if (n == 1552) check("b_p1x_next_frame",  loc[1][0], 16'h0456);
      if (n == 949)  check("b_no_fs_first_frame", 16'(fs[1]), 16'd0);
      if (n == 950)  check("b_fs_pulse",  16'(fs[1]), 16'd1);
      if (n == 951)  check("b_fs_single", 16'(fs[1]), 16'd0);
      if (n == 476)  check("c_fs_pulse",  16'(fs[2]), 16'd1);
      if (tk[2] && px[2] == 16'd0 && py[2] == 16'd12)  check("c_blank_v", 16'(bl[2]), 16'd1);
      if (tk[2] && px[2] == 16'd15 && py[2] == 16'd11) check("c_blank_last_vis", 16'(bl[2]), 16'd0);
    end
  endtask

  task automatic step(input logic [3:0] w, input logic [15:0] d);
    wr    = w;
    wdata = d;
    @(posedge clk);
    for (int i = 0; i < NCFG; i++)
      if (copy_at(cfg[i], n))
        for (int k = 0; k < 4; k++) act_m[i][k] = shadow_m[k];
    for (int k = 0; k < 4; k++)
      if (w[k]) shadow_m[k] = d;
    n++;
    cyc++;
    @(negedge clk);
    compare_all();
    directed();
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      shadow_m[k] = '0;
      for (int i = 0; i < NCFG; i++) act_m[i][k] = '0;
    end
  endtask

  task automatic mid_frame_reset();
    wr = '0;
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    n = 0;
    first_pass = 1'b0;
    compare_all();
    check("b_reset_p1x", loc[1][0], 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    #1 compare_all();
  endtask

  initial begin
    logic [3:0]  w;
    logic [15:0] d;
    cfg[0] = '{4, 0, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg[1] = '{2, 2, 16, 2, 4, 3, 12, 2, 2, 3};
    cfg[2] = '{1, 0, 16, 2, 4, 3, 12, 2, 2, 3};
    rst_n = 1'b0;
    wr = '0;
    wdata = '0;
    n = 0;
    cyc = 0;
    first_pass = 1'b1;
    n_checks = 0;
    n_fail = 0;
    hs_low_cnt = 0;
    b_fall_x = -1;
    clear_model();

    #23 compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1 compare_all();

    while (cyc < 4400) begin
      w[0] = (cyc > 1560) && ($urandom_range(7) == 0);
      w[1] = ($urandom_range(7) == 0);
      w[2] = ($urandom_range(7) == 0);
      w[3] = ($urandom_range(7) == 0);
      d    = 16'($urandom);
      if (first_pass && n == 100) begin w[0] = 1'b1; d = 16'h0123; end
      if (first_pass && n == 601) begin w[0] = 1'b1; d = 16'h0456; end
      if (first_pass && n == 3270) mid_frame_reset();
      step(w, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_timing_gen.md
# scan_timing_gen

Raster scan generator for the 640x480 display path. Produces the `pixel_x`/`pixel_y` coordinates consumed by the per-object renderers (paddles, ball, field) and the matching sync/blank strobes. It also double-buffers the two paddle positions so the renderers see positions that change only during vertical blank. It sits directly upstream of the paddle renderers and downstream of the game-logic register writes.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (4 → 25 MHz pixel rate from 100 MHz); legal range 1..16.
- `PIPE_DLY`, 1: pixel ticks by which `hsync`/`vsync`/`blank` lag `pixel_x`/`pixel_y`, matching renderer output registering; legal range 0..4.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `p1_x_wr`, `p1_y_wr`, `p2_x_wr`, `p2_y_wr` in 1 each: write strobes for the shadow position registers.
- `pos_wdata` in 16: write data shared by all four strobes.
- `pix_tick` out 1: one-clock pulse marking each new pixel.
- `pixel_x`, `pixel_y` out 16: current scan coordinates; zero-extended counter values.
- `hsync`, `vsync` out 1: active-low syncs, delayed by `PIPE_DLY`.
- `blank` out 1: high outside the 640x480 visible area, delayed by `PIPE_DLY`.
- `frame_start` out 1: one-clock pulse on the tick where the scan reaches (0,0).
- `p1_x_loc`, `p1_y_loc`, `p2_x_loc`, `p2_y_loc` out 16: active (frame-stable) paddle positions.

## Operation
- **Divider:** a counter from 0 to `CLK_DIV-1`. `pix_tick` is high when the counter equals `CLK_DIV-1`. With `CLK_DIV=1`, `pix_tick` is constantly high after reset.
- **Horizontal counter:** 0..799, advances on `pix_tick`.
  - Visible: 0..639. Front porch: 640..655. Sync: 656..751. Back porch: 752..799.
  - Wraps 799→0, and on that wrap the vertical counter increments.
- **Vertical counter:** 0..524.
  - Visible: 0..479. Front porch: 480..489. Sync: 490..491. Back porch: 492..524.
  - Wraps 524→0.
- **Raw strobes:**
  - hsync_raw = 0 when h in 656..751.
  - vsync_raw = 0 when v in 490..491.
  - blank_raw = 1 when h ≥ 640 or v ≥ 480.
- **Strobe delay:** the raw strobes pass through a `PIPE_DLY`-deep shift register clocked on `pix_tick`. `PIPE_DLY=0` is a direct combinational path.
- **Shadow registers:** four 16-bit registers.
  - Each write strobe loads `pos_wdata` into its shadow on that clock.
  - Several strobes may fire in the same clock; each loads its own shadow.
- **Active registers:** copied from all four shadows in a single clock, on the `pix_tick` where h=0 and v=480 (start of vertical blank).
  - If a write strobe coincides with the copy clock, the active register receives the old shadow value; the new value appears at the next copy.

## Timing
- **Reset values:**
  - Divider = 0, h = 0, v = 0, so `pixel_x` = `pixel_y` = 0.
  - `hsync` = `vsync` = 1.
  - `blank` = 0. Delay-line stages reset to the values for (0,0): sync high, blank low.
  - `pix_tick` = 0, `frame_start` = 0.
  - All shadow and active registers = 0.
- **Counter latency:** `pixel_x`/`pixel_y` are registered and change one clock after the `pix_tick` that advances them.
- **frame_start:** asserted on the clock in which the counters present (0,0) after a 524/799 wrap, lasting one clock. It is not asserted out of reset.
- **Frame length:** 800×525 = 420000 pixel ticks, i.e. 420000×`CLK_DIV` clocks.
- **Reset mid-frame:** reset is asynchronous and immediately returns all state to reset values. Scanning restarts at (0,0) on the first tick after release; no partial-frame state is retained.
- **Position stability:** active positions change only during v=480, which is blank. They therefore never change during a visible pixel.

## Structure
- **Shared package `display_pkg`:** holds H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525, and the 24-bit color constants used by the renderers. These are shared with the paddle, ball and field renderers.
- **Sub-module `pos_dbuf`:** one instance per coordinate (four instances), with ports: write strobe, data, copy enable, active output. All remaining logic stays in the top module.

## Test plan
- **Reset release:** release `rst_n`, `CLK_DIV=4`.
  - `pix_tick` period is 4 clocks.
  - `pixel_x` reaches 799 then 0, and `pixel_y` becomes 1, exactly 3200 clocks after the first tick.
- **Sync/blank windows**, `PIPE_DLY=0`:
  - `hsync` low exactly for x=656..751 (96 ticks).
  - `vsync` low exactly for y=490..491.
  - `blank` high at x=640,y=0 and at x=0,y=480; low at x=639,y=479.
- **Delay alignment**, `PIPE_DLY=2`: the `hsync` falling edge occurs 2 ticks after `pixel_x`=656.
- **Double buffer:**
  - Write `p1_x_wr`=0x0123 at y=100: `p1_x_loc` stays 0 until y=480,x=0, then reads 0x0123.
  - A write on the copy clock itself (0x0456) appears only one frame later.
- **Frame pulse:**
  - `frame_start` fires once per 420000 ticks and is single-clock.
  - Not present in the first frame after reset.
- **Mid-frame reset:** assert `rst_n` low at x=300,y=200 for 3 clocks.
  - Outputs go to reset values asynchronously.
  - Active positions return to 0.
  - Scan restarts from (0,0).
